// File: rtl/ov7670_capture.sv
`timescale 1ns/1ps
// ov7670_capture
// Captures RGB444 pixels from an OV7670 camera into a frame buffer RAM.
// All camera signals are oversampled in the sys_clk domain; cam_pclk is
// treated as data and its rising edges are detected after synchronization.
// Optionally decimates a 640x480 camera frame by 2 in both directions.
//
// Parameters
//   H_ACTIVE   stored frame width in pixels
//   V_ACTIVE   stored frame height in lines
//   DECIMATE   1 = keep even pixels of even lines, 0 = keep every pixel
//
// Ports
//   sys_clk            in   system clock (only clock in the block)
//   reset              in   asynchronous reset, active low
//   cam_pclk           in   camera pixel clock, sampled as data
//   cam_vsync          in   camera vertical sync, high = blanking
//   cam_href           in   camera line valid
//   cam_data[7:0]      in   camera byte bus (xxxx_RRRR, then GGGG_BBBB)
//   capture_en         in   level, 1 = capture frames continuously
//   write_RAM_address  out  buffer address, col + H_ACTIVE*row
//   write_RAM_data     out  pixel RRRR_GGGG_BBBB
//   write_RAM_en       out  single-cycle write strobe
//   ready_display      out  sticky, set after the first complete frame
//   frame_done         out  one-cycle pulse at the end of each frame
//   frame_count        out  completed-frame counter, wraps
module ov7670_capture #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int DECIMATE = 1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic [16:0] write_RAM_address,
  output logic [11:0] write_RAM_data,
  output logic        write_RAM_en,
  output logic        ready_display,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  localparam logic [16:0] H_LIM = 17'(H_ACTIVE);
  localparam logic [16:0] V_LIM = 17'(V_ACTIVE);

  state_t state_q, state_d;

  logic [1:0]  pclk_sync, vsync_sync, href_sync;
  logic [7:0]  data_sync1, data_sync2;
  logic        pclk_prev, vsync_prev, href_prev;
  logic        pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic        href_s;

  logic [10:0] x_cnt, y_cnt, x_inc, y_inc;
  logic [10:0] col, row;
  logic        phase;
  logic [3:0]  red;
  logic        pixel_keep;
  logic [16:0] pixel_addr;

  // H_ACTIVE*row as a sum of shifted copies of row, one per set bit of
  // H_ACTIVE (for 320 this is 256*row + 64*row).
  function automatic logic [16:0] times_h(input logic [16:0] r);
    logic [16:0] acc;
    acc = '0;
    for (int i = 0; i < 17; i++) begin
      if (H_LIM[i]) acc = acc + (r << i);
    end
    return acc;
  endfunction

  // Two-flop synchronizers plus a third "previous" flop for edge detection.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_sync1 <= '0;
      data_sync2 <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], cam_pclk};
      vsync_sync <= {vsync_sync[0], cam_vsync};
      href_sync  <= {href_sync[0], cam_href};
      data_sync1 <= cam_data;
      data_sync2 <= data_sync1;
      pclk_prev  <= pclk_sync[1];
      vsync_prev <= vsync_sync[1];
      href_prev  <= href_sync[1];
    end
  end

  assign href_s     = href_sync[1];
  assign pclk_rise  = pclk_sync[1] & ~pclk_prev;
  assign vsync_rise = vsync_sync[1] & ~vsync_prev;
  assign vsync_fall = ~vsync_sync[1] & vsync_prev;
  assign href_fall  = ~href_sync[1] & href_prev;

  // Counters saturate so an oversized frame can never wrap back into range.
  assign x_inc = (x_cnt == 11'h7FF) ? x_cnt : x_cnt + 11'd1;
  assign y_inc = (y_cnt == 11'h7FF) ? y_cnt : y_cnt + 11'd1;

  assign col = x_cnt >> DECIMATE;
  assign row = y_cnt >> DECIMATE;

  assign pixel_keep = ((DECIMATE == 0) || (!x_cnt[0] && !y_cnt[0])) &&
                      ({6'd0, col} < H_LIM) && ({6'd0, row} < V_LIM);

  assign pixel_addr = {6'd0, col} + times_h({6'd0, row});

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A frame in progress always runs to its vsync rise; capture_en is only
  // consulted when deciding whether to wait for another frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_en) state_d = WAIT_VS;
      WAIT_VS: if (vsync_fall) state_d = CAPTURE;
      CAPTURE: if (vsync_rise) state_d = capture_en ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel assembly and RAM write. vsync rise wins over a same-cycle href
  // fall; an odd trailing byte is simply forgotten when the line ends.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      x_cnt             <= '0;
      y_cnt             <= '0;
      phase             <= 1'b0;
      red               <= '0;
      write_RAM_address <= '0;
      write_RAM_data    <= '0;
      write_RAM_en      <= 1'b0;
      ready_display     <= 1'b0;
      frame_done        <= 1'b0;
      frame_count       <= '0;
    end else begin
      write_RAM_en <= 1'b0;
      frame_done   <= 1'b0;
      if (state_q == WAIT_VS && vsync_fall) begin
        x_cnt <= '0;
        y_cnt <= '0;
        phase <= 1'b0;
      end else if (state_q == CAPTURE) begin
        if (vsync_rise) begin
          frame_done    <= 1'b1;
          frame_count   <= frame_count + 8'd1;
          ready_display <= 1'b1;
        end else if (href_fall) begin
          y_cnt <= y_inc;
          x_cnt <= '0;
          phase <= 1'b0;
        end else if (pclk_rise && href_s) begin
          if (!phase) begin
            red   <= data_sync2[3:0];
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            x_cnt <= x_inc;
            if (pixel_keep) begin
              write_RAM_en      <= 1'b1;
              write_RAM_address <= pixel_addr;
              write_RAM_data    <= {red, data_sync2};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
`timescale 1ns/1ps
module tb_ov7670_capture;

  localparam int H = 20;
  localparam int V = 6;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        capture_en;
  logic [16:0] write_RAM_address;
  logic [11:0] write_RAM_data;
  logic        write_RAM_en;
  logic        ready_display;
  logic        frame_done;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;
  int unsigned cycle = 0;
  int unsigned last_rise = 0;
  int done_pulses = 0;
  string first_bad;

  logic [16:0] got_addr[$];
  logic [11:0] got_data[$];
  int unsigned got_cycle[$];
  logic [16:0] exp_addr[$];
  logic [11:0] exp_data[$];

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(1)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .capture_en(capture_en),
    .write_RAM_address(write_RAM_address),
    .write_RAM_data(write_RAM_data),
    .write_RAM_en(write_RAM_en),
    .ready_display(ready_display),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cycle <= cycle + 1;

  // Records every write strobe and frame_done cycle, sampled mid-period.
  always @(negedge sys_clk) begin
    if (write_RAM_en === 1'b1) begin
      got_addr.push_back(write_RAM_address);
      got_data.push_back(write_RAM_data);
      got_cycle.push_back(cycle);
    end
    if (frame_done === 1'b1) done_pulses++;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  task automatic clear_queues();
    got_addr.delete(); got_data.delete(); got_cycle.delete();
    exp_addr.delete(); exp_data.delete();
    done_pulses = 0;
  endtask

  // One camera byte: data/href change while pclk is low, pclk is 4 sys_clk.
  task automatic send_byte(input logic [7:0] b, input logic h);
    cam_data = b;
    cam_href = h;
    cam_pclk = 1'b0;
    repeat (2) @(negedge sys_clk);
    cam_pclk  = 1'b1;
    last_rise = cycle;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_gap();
    repeat ($urandom_range(1, 3)) send_byte(8'($urandom), 1'b0);
  endtask

  task automatic vsync_fall();
    cam_vsync = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic vsync_rise();
    cam_vsync = 1'b1;
    repeat (12) @(negedge sys_clk);
  endtask

  // Camera lines y0..y1-1 of random pixels; the reference model keeps every
  // other pixel of every other line that lands inside the H x V buffer.
  task automatic send_lines(input int y0, input int y1, input int nbytes, input bit model_on);
    logic [11:0] pix;
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < nbytes / 2; x++) begin
        pix = 12'($urandom);
        send_byte({4'($urandom), pix[11:8]}, 1'b1);
        send_byte(pix[7:0], 1'b1);
        if (model_on && (x % 2 == 0) && (y % 2 == 0) && (x / 2 < H) && (y / 2 < V)) begin
          exp_addr.push_back(17'((x / 2) + H * (y / 2)));
          exp_data.push_back(pix);
        end
      end
      if (nbytes % 2 == 1) send_byte(8'($urandom), 1'b1);
      send_gap();
    end
  endtask

  function automatic int count_mismatches();
    int n = 0;
    int lim;
    lim = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    first_bad = "none";
    for (int i = 0; i < lim; i++) begin
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        if (n == 0)
          first_bad = $sformatf("idx %0d got %0d/%03h expected %0d/%03h",
                                i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        n++;
      end
    end
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b0; capture_en = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    checks++; if (write_RAM_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %0b expected 0", write_RAM_en); end
    checks++; if (write_RAM_address !== 17'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", write_RAM_address); end
    checks++; if (write_RAM_data !== 12'd0) begin errors++; $display("[TB] FAIL reset_data: got %03h expected 000", write_RAM_data); end
    checks++; if (ready_display !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", ready_display); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", frame_done); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", frame_count); end
    reset = 1'b1;
    repeat (4) @(negedge sys_clk);
    checks++; if (write_RAM_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_en: got %0b expected 0", write_RAM_en); end
  endtask

  task automatic test_single_pixel();
    int unsigned t;
    capture_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    clear_queues();
    vsync_fall();
    send_byte(8'h0A, 1'b1);
    send_byte(8'h5C, 1'b1);
    t = last_rise;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h0B, 1'b1); send_byte(8'h6D, 1'b1);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    vsync_rise();
    checks++; if (got_addr.size() !== 1) begin errors++; $display("[TB] FAIL single_count: got %0d writes expected 1", got_addr.size()); end
    if (got_addr.size() > 0) begin
      checks++; if (got_addr[0] !== 17'd0) begin errors++; $display("[TB] FAIL single_addr: got %0d expected 0", got_addr[0]); end
      checks++; if (got_data[0] !== 12'hA5C) begin errors++; $display("[TB] FAIL single_data: got %03h expected a5c", got_data[0]); end
      checks++; if (got_cycle[0] !== t + 3) begin errors++; $display("[TB] FAIL single_timing: got cycle %0d expected %0d", got_cycle[0], t + 3); end
    end
    checks++; if (done_pulses !== 1) begin errors++; $display("[TB] FAIL single_done: got %0d pulse cycles expected 1", done_pulses); end
    checks++; if (ready_display !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %0b expected 1", ready_display); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("[TB] FAIL single_fcount: got %0d expected 1", frame_count); end
  endtask

  task automatic test_random_frame();
    int mm;
    clear_queues();
    vsync_fall();
    send_lines(0, 2 * V, 4 * H, 1'b1);
    vsync_rise();
    mm = count_mismatches();
    checks++; if (got_addr.size() !== H * V) begin errors++; $display("[TB] FAIL frame_count_writes: got %0d expected %0d", got_addr.size(), H * V); end
    checks++; if (mm !== 0) begin errors++; $display("[TB] FAIL frame_pixels: got %0d mismatches expected 0 (%s)", mm, first_bad); end
    if (got_addr.size() > 0) begin
      checks++; if (got_addr[$] !== 17'(H * V - 1)) begin errors++; $display("[TB] FAIL frame_last_addr: got %0d expected %0d", got_addr[$], H * V - 1); end
    end
    checks++; if (done_pulses !== 1) begin errors++; $display("[TB] FAIL frame_done: got %0d expected 1", done_pulses); end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("[TB] FAIL frame_fcount: got %0d expected 2", frame_count); end
  endtask

  task automatic test_oversize();
    int mm;
    int nbytes;
    logic [16:0] max_a;
    clear_queues();
    nbytes = 4 * H + 2 * $urandom_range(3, 10) + 1;
    vsync_fall();
    send_lines(0, 2 * V + 5, nbytes, 1'b1);
    vsync_rise();
    mm = count_mismatches();
    max_a = '0;
    foreach (got_addr[i]) if (got_addr[i] > max_a) max_a = got_addr[i];
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("[TB] FAIL over_writes: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
    checks++; if (mm !== 0) begin errors++; $display("[TB] FAIL over_pixels: got %0d mismatches expected 0 (%s)", mm, first_bad); end
    checks++; if (max_a >= 17'(H * V)) begin errors++; $display("[TB] FAIL over_max_addr: got %0d expected below %0d", max_a, H * V); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("[TB] FAIL over_fcount: got %0d expected 3", frame_count); end
  endtask

  task automatic test_capture_en_drop();
    int mm;
    clear_queues();
    vsync_fall();
    send_lines(0, V, 4 * H, 1'b1);
    capture_en = 1'b0;
    send_lines(V, 2 * V, 4 * H, 1'b1);
    vsync_rise();
    mm = count_mismatches();
    checks++; if (got_addr.size() !== H * V) begin errors++; $display("[TB] FAIL drop_writes: got %0d expected %0d", got_addr.size(), H * V); end
    checks++; if (mm !== 0) begin errors++; $display("[TB] FAIL drop_pixels: got %0d mismatches expected 0 (%s)", mm, first_bad); end
    checks++; if (frame_count !== 8'd4) begin errors++; $display("[TB] FAIL drop_fcount: got %0d expected 4", frame_count); end
    clear_queues();
    vsync_fall();
    send_lines(0, 2 * V, 4 * H, 1'b0);
    vsync_rise();
    checks++; if (got_addr.size() !== 0) begin errors++; $display("[TB] FAIL drop_next_writes: got %0d expected 0", got_addr.size()); end
    checks++; if (done_pulses !== 0) begin errors++; $display("[TB] FAIL drop_next_done: got %0d expected 0", done_pulses); end
    checks++; if (frame_count !== 8'd4) begin errors++; $display("[TB] FAIL drop_next_fcount: got %0d expected 4", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int mm;
    capture_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    clear_queues();
    vsync_fall();
    send_lines(0, 4, 4 * H, 1'b0);
    @(negedge sys_clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (write_RAM_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_en: got %0b expected 0", write_RAM_en); end
    checks++; if (write_RAM_address !== 17'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d expected 0", write_RAM_address); end
    checks++; if (write_RAM_data !== 12'd0) begin errors++; $display("[TB] FAIL midrst_data: got %03h expected 000", write_RAM_data); end
    checks++; if (ready_display !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %0b expected 0", ready_display); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_fcount: got %0d expected 0", frame_count); end
    @(negedge sys_clk);
    reset = 1'b1;
    clear_queues();
    send_lines(4, 2 * V, 4 * H, 1'b0);
    vsync_rise();
    checks++; if (got_addr.size() !== 0) begin errors++; $display("[TB] FAIL midrst_partial_writes: got %0d expected 0", got_addr.size()); end
    checks++; if (done_pulses !== 0) begin errors++; $display("[TB] FAIL midrst_partial_done: got %0d expected 0", done_pulses); end
    clear_queues();
    vsync_fall();
    send_lines(0, 2 * V, 4 * H, 1'b1);
    vsync_rise();
    mm = count_mismatches();
    checks++; if (got_addr.size() !== H * V) begin errors++; $display("[TB] FAIL midrst_full_writes: got %0d expected %0d", got_addr.size(), H * V); end
    checks++; if (mm !== 0) begin errors++; $display("[TB] FAIL midrst_full_pixels: got %0d mismatches expected 0 (%s)", mm, first_bad); end
    if (got_addr.size() > 0) begin
      checks++; if (got_addr[0] !== 17'd0) begin errors++; $display("[TB] FAIL midrst_first_addr: got %0d expected 0", got_addr[0]); end
    end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("[TB] FAIL midrst_fcount_after: got %0d expected 1", frame_count); end
    checks++; if (ready_display !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready_after: got %0b expected 1", ready_display); end
  endtask

  task automatic test_frame_count_wrap();
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b1;
    capture_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    clear_queues();
    for (int f = 0; f < 256; f++) begin
      cam_vsync = 1'b0;
      repeat ($urandom_range(6, 9)) @(negedge sys_clk);
      cam_vsync = 1'b1;
      repeat ($urandom_range(6, 9)) @(negedge sys_clk);
      if (f == 254) begin
        checks++; if (frame_count !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255: got %0d expected 255", frame_count); end
      end
    end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d expected 0", frame_count); end
    checks++; if (ready_display !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready: got %0b expected 1", ready_display); end
    checks++; if (done_pulses !== 256) begin errors++; $display("[TB] FAIL wrap_done: got %0d expected 256", done_pulses); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_random_frame();
    test_oversize();
    test_capture_en_drop();
    test_reset_mid_frame();
    test_frame_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
